// File: rtl/frame_readout_if.sv
// Pixel-write and byte-readout bus of frame_readout.
// master = controller/consumer side, slave = frame_readout.
interface frame_readout_if;
   logic       write_enable;
   logic [7:0] out_pxl_row;
   logic [8:0] out_pxl_col;
   logic       data_in;
   logic       done;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       byte_last;
   logic       busy;
   logic       addr_err;
   logic [1:0] state_dbg;

   // Handshake: byte_out/byte_last hold steady while byte_valid is high;
   // the byte moves on the rising edge where byte_valid && byte_ready.
   modport master (
      output write_enable, out_pxl_row, out_pxl_col, data_in, done, byte_ready,
      input  byte_out, byte_valid, byte_last, busy, addr_err, state_dbg
   );

   modport slave (
      input  write_enable, out_pxl_row, out_pxl_col, data_in, done, byte_ready,
      output byte_out, byte_valid, byte_last, busy, addr_err, state_dbg
   );
endinterface

// File: rtl/frame_readout.sv
// Binary frame store (8 one-bit banks) with byte-packed readout stream.
// Optional trailing XOR checksum byte: define FRAME_READOUT_CHECKSUM_EN.
module frame_readout #(
   parameter int ROWS = 240,
   parameter int COLS = 320
) (
   input logic            clk,
   input logic            reset,
   frame_readout_if.slave bus
);
   localparam int WORDS  = ROWS * COLS / 8;
   localparam int GROUPS = COLS / 8;
   localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
`ifdef FRAME_READOUT_CHECKSUM_EN
      , CKSUM = 2'd3
`endif
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] ptr;
   logic              bank_mem [8][WORDS];
   logic              in_range;
   logic              wr_en;
   logic [WORD_W-1:0] wr_word;
`ifdef FRAME_READOUT_CHECKSUM_EN
   logic [7:0]        cksum;
`endif

   assign in_range = ({24'd0, bus.out_pxl_row} < ROWS) && ({23'd0, bus.out_pxl_col} < COLS);
   assign wr_word  = WORD_W'(bus.out_pxl_row) * WORD_W'(GROUPS) + WORD_W'(bus.out_pxl_col[8:3]);
   // Writes are only honoured while idle, including the cycle that done arrives.
   assign wr_en    = reset && (state == IDLE) && bus.write_enable && in_range;

   assign bus.busy      = (state != IDLE);
   assign bus.state_dbg = state;

   // Storage is never reset so a frame survives aborted readouts.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank_mem[bus.out_pxl_col[2:0]][wr_word] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         ptr            <= '0;
         bus.byte_out   <= 8'h00;
         bus.byte_valid <= 1'b0;
         bus.byte_last  <= 1'b0;
         bus.addr_err   <= 1'b0;
`ifdef FRAME_READOUT_CHECKSUM_EN
         cksum          <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.write_enable && !in_range) begin
                  bus.addr_err <= 1'b1;
               end
               if (bus.done) begin
                  ptr   <= '0;
                  state <= FETCH;
`ifdef FRAME_READOUT_CHECKSUM_EN
                  cksum <= 8'h00;
`endif
               end
            end
            FETCH: begin
               // Bank 0 holds the lowest column of the group, which lands in bit 7.
               for (int b = 0; b < 8; b++) begin
                  bus.byte_out[7-b] <= bank_mem[b][ptr];
               end
               bus.byte_valid <= 1'b1;
`ifdef FRAME_READOUT_CHECKSUM_EN
               bus.byte_last  <= 1'b0;
`else
               bus.byte_last  <= (ptr == LAST_WORD);
`endif
               state <= SEND;
            end
            SEND: begin
               if (bus.byte_ready) begin
`ifdef FRAME_READOUT_CHECKSUM_EN
                  cksum <= cksum ^ bus.byte_out;
`endif
                  if (ptr == LAST_WORD) begin
                     ptr <= '0;
`ifdef FRAME_READOUT_CHECKSUM_EN
                     bus.byte_out   <= cksum ^ bus.byte_out;
                     bus.byte_valid <= 1'b1;
                     bus.byte_last  <= 1'b1;
                     state          <= CKSUM;
`else
                     bus.byte_valid <= 1'b0;
                     bus.byte_last  <= 1'b0;
                     state          <= IDLE;
`endif
                  end else begin
                     ptr            <= ptr + 1'b1;
                     bus.byte_valid <= 1'b0;
                     bus.byte_last  <= 1'b0;
                     state          <= FETCH;
                  end
               end
            end
`ifdef FRAME_READOUT_CHECKSUM_EN
            CKSUM: begin
               if (bus.byte_ready) begin
                  bus.byte_valid <= 1'b0;
                  bus.byte_last  <= 1'b0;
                  state          <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_readout.sv
// Self-checking bench for frame_readout on a reduced 30x40 frame.
module tb_frame_readout;
   localparam int ROWS  = 30;
   localparam int COLS  = 40;
   localparam int WORDS = ROWS * COLS / 8;
`ifdef FRAME_READOUT_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         img [ROWS][COLS];
   logic       exp_addr_err;
   logic [7:0] first_byte;
   logic [7:0] last_pix_byte;
   int         n_bytes;

   frame_readout_if bus ();

   frame_readout #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_px(input int r, input int c, input bit d);
      bus.write_enable = 1'b1;
      bus.out_pxl_row  = 8'(r);
      bus.out_pxl_col  = 9'(c);
      bus.data_in      = d;
      step();
      bus.write_enable = 1'b0;
      if (r < ROWS && c < COLS) img[r][c] = d;
      else exp_addr_err = 1'b1;
   endtask

   task automatic fill(input bit rnd);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            write_px(r, c, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
   endtask

   // Expected stream straight from the image: one byte per 8-pixel group, row-major.
   task automatic build_expected();
      logic [7:0] b;
      logic [7:0] x;
      exp_q.delete();
      x = 8'h00;
      for (int w = 0; w < WORDS; w++) begin
         for (int i = 0; i < 8; i++)
            b[7-i] = img[w / (COLS/8)][(w % (COLS/8)) * 8 + i];
         exp_q.push_back(b);
         x ^= b;
      end
      if (CK == 1) exp_q.push_back(x);
   endtask

   task automatic readout(input int abort_after, input bit rnd_ready, input int stall_at,
                          input bit disturb, input bit co_write, input int cr, input int cc,
                          input bit cd);
      int         n;
      int         cyc;
      int         budget;
      logic [7:0] e;
      logic [7:0] held;
      bit         stalled;
      if (co_write) begin
         bus.write_enable = 1'b1;
         bus.out_pxl_row  = 8'(cr);
         bus.out_pxl_col  = 9'(cc);
         bus.data_in      = cd;
         img[cr][cc]      = cd;
      end
      build_expected();
      budget  = 10 * exp_q.size() + 50;
      n       = 0;
      cyc     = 0;
      stalled = 1'b0;
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.write_enable = 1'b0;
      while (exp_q.size() > 0 && !(abort_after > 0 && n >= abort_after) && cyc < budget) begin
         if (cyc == 2) chk("busy_during_readout", bus.busy, 1);
         if (stall_at >= 0 && n == stall_at && !stalled && bus.byte_valid) begin
            held = bus.byte_out;
            bus.byte_ready = 1'b0;
            stalled = 1'b1;
            for (int k = 0; k < 5; k++) begin
               step();
               cyc++;
               chk("stall_valid_held", bus.byte_valid, 1);
               chk("stall_byte_stable", bus.byte_out, held);
            end
         end
         bus.byte_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (disturb && cyc == 6) begin
            bus.write_enable = 1'b1;
            bus.out_pxl_row  = 8'd0;
            bus.out_pxl_col  = 9'd0;
            bus.data_in      = 1'b1;
            bus.done         = 1'b1;
         end
         if (disturb && cyc == 9) begin
            bus.write_enable = 1'b1;
            bus.out_pxl_row  = 8'hff;
            bus.out_pxl_col  = 9'h1ff;
            bus.data_in      = 1'b1;
         end
         if (bus.byte_valid && bus.byte_ready) begin
            e = exp_q.pop_front();
            chk("byte_out", bus.byte_out, e);
            chk("byte_last", bus.byte_last, exp_q.size() == 0);
            if (n == 0) first_byte = bus.byte_out;
            if (n == WORDS - 1) last_pix_byte = bus.byte_out;
            n++;
         end
         step();
         cyc++;
         bus.write_enable = 1'b0;
         bus.done = 1'b0;
      end
      bus.byte_ready = 1'b0;
      n_bytes = n;
      chk("readout_in_budget", cyc < budget, 1);
      if (abort_after > 0) begin
         reset = 1'b0;
         step();
         chk("abort_valid", bus.byte_valid, 0);
         chk("abort_busy", bus.busy, 0);
         chk("abort_last", bus.byte_last, 0);
         chk("abort_byte_out", bus.byte_out, 8'h00);
         chk("abort_addr_err", bus.addr_err, 0);
         reset = 1'b1;
         exp_addr_err = 1'b0;
         repeat (4) step();
         chk("abort_no_more_bytes", bus.byte_valid, 0);
      end else begin
         chk("end_busy", bus.busy, 0);
         chk("end_valid", bus.byte_valid, 0);
         chk("end_addr_err", bus.addr_err, exp_addr_err);
      end
   endtask

   initial begin
      bus.write_enable = 1'b0;
      bus.out_pxl_row  = 8'd0;
      bus.out_pxl_col  = 9'd0;
      bus.data_in      = 1'b0;
      bus.done         = 1'b0;
      bus.byte_ready   = 1'b0;
      reset            = 1'b0;
      exp_addr_err     = 1'b0;
      repeat (3) step();
      chk("rst_byte_valid", bus.byte_valid, 0);
      chk("rst_byte_last", bus.byte_last, 0);
      chk("rst_byte_out", bus.byte_out, 8'h00);
      chk("rst_busy", bus.busy, 0);
      chk("rst_addr_err", bus.addr_err, 0);
      reset = 1'b1;
      step();

      // Two corner pixels of row 0, full-rate readout.
      fill(1'b0);
      write_px(0, 0, 1'b1);
      write_px(0, 7, 1'b1);
      readout(0, 1'b0, -1, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("first_byte_81", first_byte, 8'h81);
      chk("byte_count", n_bytes, WORDS + CK);

      // Random frame, random backpressure, a 5-cycle stall, a write alongside done,
      // and writes/done issued mid-readout that must be ignored.
      fill(1'b1);
      readout(0, 1'b1, 10, 1'b1, 1'b1, 3, 17, 1'b1);

      // Out-of-range writes: flag sets, sticks, storage untouched.
      write_px(ROWS, 0, 1'b1);
      chk("addr_err_row", bus.addr_err, 1);
      write_px(0, COLS, 1'b1);
      chk("addr_err_col", bus.addr_err, 1);
      write_px(255, 511, 1'b1);
      write_px(5, 5, ~img[5][5]);
      chk("addr_err_sticky", bus.addr_err, 1);
      readout(0, 1'b1, -1, 1'b0, 1'b0, 0, 0, 1'b0);

      // Abort after 100 bytes, then a full readout from word 0 with data intact.
      readout(100, 1'b0, -1, 1'b0, 1'b0, 0, 0, 1'b0);
      readout(0, 1'b1, -1, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("restart_byte_count", n_bytes, WORDS + CK);

      // Only the last pixel set; a (0,0) write during readout must not land.
      fill(1'b0);
      write_px(ROWS - 1, COLS - 1, 1'b1);
      readout(0, 1'b0, -1, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("last_pixel_byte", last_pix_byte, 8'h01);
      readout(0, 1'b0, -1, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("ignored_write_first_byte", first_byte, 8'h00);
      chk("last_pixel_byte_again", last_pix_byte, 8'h01);
      chk("final_byte_count", n_bytes, WORDS + CK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_readout.md
FRAME_READOUT -- requirements
Module: frame_readout

Interface
REQ-001 Parameter ROWS, default 240, number of image rows stored.
REQ-002 Parameter COLS, default 320, number of image columns stored; SHALL be a multiple of 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 write_enable  input  1  pixel write strobe from the processing controller.
REQ-006 out_pxl_row  input  8  row address of the written pixel.
REQ-007 out_pxl_col  input  9  column address of the written pixel.
REQ-008 data_in  input  1  binary pixel value to store.
REQ-009 done  input  1  controller frame-complete pulse; starts readout.
REQ-010 byte_out  output  8  packed pixel byte; bit 7 = lowest column of the group.
REQ-011 byte_valid  output  1  byte_out holds a valid byte.
REQ-012 byte_ready  input  1  downstream accepts the byte.
REQ-013 byte_last  output  1  high with the final byte of the frame.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 addr_err  output  1  sticky flag for an out-of-range write.

Function
REQ-016 Storage SHALL be 8 one-bit banks, each ROWS*COLS/8 deep; bank = col[2:0], word = row*(COLS/8) + col[8:3].
REQ-017 States SHALL be IDLE, FETCH, SEND, CKSUM (macro only), with IDLE as the reset state.
REQ-018 IDLE: write_enable with row<ROWS and col<COLS SHALL store data_in in the same cycle, one pixel per cycle.
REQ-019 IDLE: write_enable with row>=ROWS or col>=COLS SHALL be dropped and SHALL set addr_err.
REQ-020 write_enable outside IDLE SHALL be ignored; no store, no addr_err.
REQ-021 IDLE with done=1 SHALL go to FETCH with word pointer 0; a write in that same cycle SHALL still be stored.
REQ-022 FETCH: issue a synchronous read of all 8 banks at the pointer; data available next cycle; next state SEND.
REQ-023 SEND: byte_valid=1 and byte_out stable until byte_valid&&byte_ready.
REQ-024 On transfer, the pointer SHALL increment and the state SHALL return to FETCH, giving at most one byte per 2 cycles.
REQ-025 On transfer of word ROWS*COLS/8-1, the next state SHALL be CKSUM if the macro is defined, else IDLE.
REQ-026 byte_last SHALL equal byte_valid on the final byte of the frame stream.
REQ-027 done outside IDLE SHALL be ignored.
REQ-028 Storage contents SHALL persist across readouts; pixels not rewritten SHALL keep their previous values.

Reset
REQ-029 reset=0 at a clock edge SHALL force state IDLE, pointer 0, byte_valid 0, byte_last 0, byte_out 0x00, busy 0, addr_err 0, checksum 0.
REQ-030 reset mid-readout SHALL abort the readout with no further bytes; storage contents are not cleared.

Configuration
REQ-031 Macro FRAME_READOUT_CHECKSUM_EN SHALL control an extra checksum byte after the frame.
REQ-032 Macro defined: 8-bit checksum = XOR of all transferred frame bytes, sent in CKSUM with the same handshake; byte_last marks the checksum byte, not the final pixel byte.
REQ-033 Macro undefined: no CKSUM state and no checksum logic.

Verification
REQ-034 Write pixels (0,0)=1 and (0,7)=1, all others 0; pulse done with byte_ready=1 -> first byte 0x81, then 9599 bytes 0x00 with byte_last on byte 9600 (macro off).
REQ-035 Hold byte_ready=0 for 5 cycles during SEND -> byte_valid stays 1 and byte_out stays unchanged; exactly one transfer once byte_ready=1.
REQ-036 Write row=240 col=0, then row=0 col=320 -> addr_err=1, storage unchanged, addr_err stays 1 until reset.
REQ-037 Pulse reset=0 after 100 bytes of readout -> next cycle byte_valid=0, busy=0; a later done restarts at word 0 with the earlier data intact.
REQ-038 Macro on, only pixel (239,319)=1 -> final pixel byte 0x01, then checksum byte 0x01 with byte_last; total 9601 bytes.
REQ-039 write_enable during readout at (0,0) with data_in=1 on an all-zero frame -> ignored; the next readout's first byte is 0x00.
